fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the MIPS pipeline. Owns the program counter, drives the instruction memory's byte address, captures the combinationally returned instruction word into a small prefetch queue, and presents {instruction, PC, PC+4} to decode through a valid/ready handshake. Branch/jump redirects from downstream flush the queue and reload the PC.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `QDEPTH`, 2: prefetch queue entries; power of two, at least 2.

- `clk`  in  1  rising-edge clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_addr`  out  32  byte address to instruction memory; always equals the current PC.
- `imem_instr`  in  32  word returned by instruction memory for `imem_addr`; valid in the same cycle (combinational read).
- `redirect_valid`  in  1  branch/jump taken this cycle.
- `redirect_pc`  in  32  target byte address; sampled when `redirect_valid`=1.
- `out_valid`  out  1  queue head holds a valid entry.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  instruction at queue head.
- `out_pc`  out  32  byte address of `out_instr`.
- `out_pc_plus4`  out  32  `out_pc`+4, modulo 2^32.
- `misalign`  out  1  sticky misaligned-redirect flag; exists only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- State: `pc` (32 b), circular queue of QDEPTH entries {instr, pc}, read pointer, write pointer, and a count of width log2(QDEPTH)+1.
- Push: when `count < QDEPTH` at the start of the cycle and `redirect_valid`=0, the unit writes {`imem_instr`, `pc`} at the write pointer and sets `pc` ← `pc`+4. The push decision ignores a pop in the same cycle, so a full queue never pushes.
- Pop: occurs when `out_valid` && `out_ready` && !`redirect_valid`; the read pointer advances.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect (highest priority): count ← 0, both pointers ← 0, `pc` ← `redirect_pc`. Any push or pop in that cycle is discarded, and the head entry is not consumed.
- Outputs are driven from the queue head (registered state): `out_valid` = (count ≠ 0). When `out_valid`=0, `out_instr`, `out_pc` and `out_pc_plus4` are don't-care.
- PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Pointers wrap modulo QDEPTH.
- The unit performs no range check. Addresses at or beyond 4096 are the program's responsibility.

## Timing
- Reset values: `pc`=RESET_PC, count=0, pointers=0, `out_valid`=0, `misalign`=0. `imem_addr`=RESET_PC during and after the reset cycle.
- First instruction: the first edge with `reset`=0 pushes the RESET_PC entry, so `out_valid`=1 in the following cycle. Fetch-to-decode latency is 1 cycle.
- Throughput: with `out_ready` held at 1, the unit delivers one instruction per cycle indefinitely.
- Redirect latency: with `redirect_valid` at edge N, the target is pushed at edge N+1 and presented with `out_valid`=1 after N+1. The bubble is exactly 1 cycle.
- Reset mid-operation overrides all other inputs, including a redirect, and discards queue contents.
- Stall: with `out_ready`=0, the queue fills to QDEPTH and then `pc` holds. `imem_addr` stays at the next unfetched address.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 flushes the queue and sets `misalign`=1 (sticky until reset).
  - `pc` is not loaded, and all pushes stop until reset.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - There is no `misalign` port.
  - `redirect_pc[1:0]` is ignored and `pc` ← {`redirect_pc[31:2]`, 2'b00}.

## Test plan
- Reset, then `out_ready`=1 with memory words 0..3 = A,B,C,D: `out_valid` rises one cycle after reset release. The bench sees A@0, B@4, C@8, D@12 on consecutive cycles, with `out_pc_plus4` = 4, 8, 12, 16.
- Hold `out_ready`=0 for 5 cycles after reset: count saturates at 2, `imem_addr`=8 held, and the head stays A. Releasing `out_ready` yields A, B, C in back-to-back cycles.
- Redirect to 0x40 while the head is B and `out_ready`=1: B is not consumed, `out_valid`=0 for one cycle, and the next accepted entry is {instr@0x40, 0x40}.
- Redirect and pop in the same cycle with a full queue: count becomes 0, and the next cycle holds exactly one entry, from the target.
- Set `pc` to 0xFFFF_FFFC via redirect: the following entry has `out_pc`=0 and `out_pc_plus4` of the wrapping entry is 0.
- Redirect to 0x42: with `FETCH_MISALIGN_TRAP_EN`, `misalign`=1 and no further `out_valid`. Without it, the entry at 0x40 is delivered.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's instruction-memory port, the
// redirect input from downstream and the decode-side output handshake.
//
// Signals
//   imem_addr     byte address to instruction memory (current PC)
//   imem_instr    word returned combinationally for imem_addr
//   redirect_valid / redirect_pc   branch/jump taken and its target
//   out_valid / out_ready          decode handshake
//   out_instr / out_pc / out_pc_plus4   queue head payload
//
// Modports
//   master  side used by fetch_unit
//   slave   side used by memory / decode / testbench
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output out_pc_plus4
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  out_pc_plus4
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch stage. Owns the PC, drives the
// instruction memory address, captures the returned word into a small
// circular prefetch queue and presents {instr, pc, pc+4} to decode.
// Downstream redirects flush the queue and reload the PC.
//
// Parameters
//   RESET_PC  PC loaded on reset
//   QDEPTH    prefetch queue entries (power of two, >= 2)
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   bus       fetch_unit_if.master (imem, redirect, decode handshake)
//   misalign  sticky misaligned-redirect flag (FETCH_MISALIGN_TRAP_EN only)
//
// Build option
//   FETCH_MISALIGN_TRAP_EN  when defined, a redirect to a non-word-aligned
//   target flushes, raises misalign and halts fetching until reset. When
//   undefined, the low two target bits are simply dropped.
//
// Handshake: an entry transfers to decode on a rising edge where
// out_valid=1, out_ready=1 and redirect_valid=0. out_valid and the payload
// come from registered queue state only and never depend on out_ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic clk,
    input  logic reset,
    fetch_unit_if.master bus
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic misalign
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(QDEPTH);

    logic [31:0]   pc;
    logic [31:0]   q_instr [QDEPTH];
    logic [31:0]   q_pc    [QDEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          push;
    logic          pop;
    logic          load_pc;
    logic          halt;
    logic [31:0]   target;

    always_comb begin
        halt    = 1'b0;
        load_pc = bus.redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        // Once trapped, nothing more is fetched; a misaligned target is
        // never loaded into the PC.
        halt    = misalign;
        load_pc = bus.redirect_valid && (bus.redirect_pc[1:0] == 2'b00);
`endif
        target  = {bus.redirect_pc[31:2], 2'b00};
        // Push looks at the count before any same-cycle pop, so a full
        // queue never pushes even while decode is draining it.
        push    = !bus.redirect_valid && (count < FULL) && !halt;
        pop     = !bus.redirect_valid && (count != '0) && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (load_pc) begin
                pc <= target;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Queue storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_instr[wr_ptr] <= bus.imem_instr;
            q_pc[wr_ptr]    <= pc;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end
`endif

    assign bus.imem_addr    = pc;
    assign bus.out_valid    = (count != '0);
    assign bus.out_instr    = q_instr[rd_ptr];
    assign bus.out_pc       = q_pc[rd_ptr];
    assign bus.out_pc_plus4 = q_pc[rd_ptr] + 32'd4;
endmodule
